// File: rtl/riscv_test_monitor_pkg.sv
// Shared types and constants for the riscv-tests pass/fail monitor.
// Register indices follow the RISC-V ABI names used by the test programs.
package test_mon_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DONE   = 2'd2
  } mon_state_t;

  localparam int unsigned ABI_GP  = 3;
  localparam int unsigned ABI_S10 = 26;
  localparam int unsigned ABI_S11 = 27;

  localparam int unsigned DEF_SETTLE_CYC  = 10;
  localparam int unsigned DEF_TIMEOUT_CYC = 100000;

endpackage

// File: rtl/mon_sat_cnt.sv
// Saturating up-counter with synchronous clear and count enable.
module mon_sat_cnt #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/riscv_test_monitor.sv
// Snoops register-file write-back, shadows the test-number/done/pass registers
// and renders a sticky verdict after a settle window or a watchdog timeout.
module riscv_test_monitor
  import test_mon_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned TNUM_REG    = ABI_GP,
  parameter int unsigned DONE_REG    = ABI_S10,
  parameter int unsigned PASS_REG    = ABI_S11,
  parameter int unsigned SETTLE_CYC  = DEF_SETTLE_CYC,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int unsigned CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_we_i,
  input  logic [ADDR_W-1:0] wb_waddr_i,
  input  logic [DATA_W-1:0] wb_wdata_i,
  input  logic              clear_i,
  output logic              test_done_o,
  output logic              test_pass_o,
  output logic              test_fail_o,
  output logic              test_timeout_o,
  output logic [DATA_W-1:0] test_num_o,
  output logic [CNT_W-1:0]  cycle_cnt_o
);

  localparam int unsigned       SET_W        = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SET_W-1:0]  SETTLE_LAST  = SET_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [DATA_W-1:0] ONE          = DATA_W'(1);

  mon_state_t        state_q, state_d;
  logic [DATA_W-1:0] tnum_q, done_q, pass_q;
  logic [CNT_W-1:0]  cycle_cnt;
  logic [SET_W-1:0]  settle_cnt;
  logic              wr_ok, trigger;
  logic              enter_done, verdict_pass, verdict_timeout;

  // x0 writes are architecturally void, and shadows freeze once a verdict exists
  assign wr_ok   = wb_we_i && (wb_waddr_i != '0) && (state_q != ST_DONE);
  assign trigger = (done_q == ONE) || (pass_q == ONE);

  mon_sat_cnt #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear_i),
    .en    (state_q != ST_DONE),
    .cnt   (cycle_cnt)
  );

  mon_sat_cnt #(.W(SET_W)) u_settle_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear_i || (state_q != ST_SETTLE)),
    .en    (state_q == ST_SETTLE),
    .cnt   (settle_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Trigger outranks the watchdog; the watchdog is only armed in RUN
  always_comb begin
    state_d         = state_q;
    enter_done      = 1'b0;
    verdict_pass    = 1'b0;
    verdict_timeout = 1'b0;
    if (clear_i) begin
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (trigger) begin
            state_d = ST_SETTLE;
          end else if ((TIMEOUT_CYC != 0) && (cycle_cnt == TIMEOUT_LAST)) begin
            state_d         = ST_DONE;
            enter_done      = 1'b1;
            verdict_timeout = 1'b1;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state_d      = ST_DONE;
            enter_done   = 1'b1;
            verdict_pass = (done_q == ONE) && (pass_q == ONE);
          end
        end
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tnum_q <= '0;
      done_q <= '0;
      pass_q <= '0;
    end else if (clear_i) begin
      tnum_q <= '0;
      done_q <= '0;
      pass_q <= '0;
    end else if (wr_ok) begin
      if (wb_waddr_i == ADDR_W'(TNUM_REG)) tnum_q <= wb_wdata_i;
      if (wb_waddr_i == ADDR_W'(DONE_REG)) done_q <= wb_wdata_i;
      if (wb_waddr_i == ADDR_W'(PASS_REG)) pass_q <= wb_wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      test_done_o    <= 1'b0;
      test_pass_o    <= 1'b0;
      test_fail_o    <= 1'b0;
      test_timeout_o <= 1'b0;
      test_num_o     <= '0;
    end else if (clear_i) begin
      test_done_o    <= 1'b0;
      test_pass_o    <= 1'b0;
      test_fail_o    <= 1'b0;
      test_timeout_o <= 1'b0;
      test_num_o     <= '0;
    end else if (enter_done) begin
      test_done_o    <= 1'b1;
      test_pass_o    <= verdict_pass;
      test_fail_o    <= !verdict_pass;
      test_timeout_o <= verdict_timeout;
      test_num_o     <= tnum_q;
    end
  end

  assign cycle_cnt_o = cycle_cnt;

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Bench for riscv_test_monitor: directed vector table, hand sequences and
// randomized traffic, all checked against an edge-numbered reference model.
module tb_riscv_test_monitor;

  localparam int SETTLE = 10;
  localparam int TO_A   = 50;
  localparam int TO_B   = 0;

  localparam logic [4:0] GP  = 5'd3;
  localparam logic [4:0] S10 = 5'd26;
  localparam logic [4:0] S11 = 5'd27;

  typedef struct packed {
    logic        done;
    logic        pass;
    logic        fail;
    logic        tmo;
    logic [31:0] num;
    logic [31:0] cyc;
  } out_t;

  typedef struct {
    int          rep;
    bit          we;
    logic [4:0]  addr;
    logic [31:0] data;
    bit          clr;
    out_t        exp;
  } vec_t;

  // Edge n after clear: shadows, the edge on which settling began, verdict
  typedef struct {
    int unsigned n;
    logic [31:0] tn;
    logic [31:0] dn;
    logic [31:0] ps;
    int          sstart;
    bit          vd;
    bit          vp;
    bit          vt;
    logic [31:0] vn;
  } model_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        clear;

  logic        a_done, a_pass, a_fail, a_to, b_done, b_pass, b_fail, b_to;
  logic [31:0] a_num, a_cyc, b_num, b_cyc;
  out_t        out_a, out_b;

  int     total = 0;
  int     bad   = 0;
  model_t ma, mb;
  vec_t   vecs[27];

  always #5 clk = ~clk;

  riscv_test_monitor #(.SETTLE_CYC(SETTLE), .TIMEOUT_CYC(TO_A)) dut (
    .clk(clk), .rst_n(rst_n), .wb_we_i(wb_we), .wb_waddr_i(wb_waddr),
    .wb_wdata_i(wb_wdata), .clear_i(clear), .test_done_o(a_done),
    .test_pass_o(a_pass), .test_fail_o(a_fail), .test_timeout_o(a_to),
    .test_num_o(a_num), .cycle_cnt_o(a_cyc)
  );

  riscv_test_monitor #(.SETTLE_CYC(SETTLE), .TIMEOUT_CYC(TO_B)) dut_nt (
    .clk(clk), .rst_n(rst_n), .wb_we_i(wb_we), .wb_waddr_i(wb_waddr),
    .wb_wdata_i(wb_wdata), .clear_i(clear), .test_done_o(b_done),
    .test_pass_o(b_pass), .test_fail_o(b_fail), .test_timeout_o(b_to),
    .test_num_o(b_num), .cycle_cnt_o(b_cyc)
  );

  assign out_a = {a_done, a_pass, a_fail, a_to, a_num, a_cyc};
  assign out_b = {b_done, b_pass, b_fail, b_to, b_num, b_cyc};

  function automatic model_t zeroModel();
    model_t m;
    m.n = 0; m.tn = '0; m.dn = '0; m.ps = '0; m.sstart = -1;
    m.vd = 1'b0; m.vp = 1'b0; m.vt = 1'b0; m.vn = '0;
    return m;
  endfunction

  function automatic model_t stepModel(model_t m, bit we, logic [4:0] a,
                                       logic [31:0] d, bit clr, int to);
    int unsigned e;
    if (clr) return zeroModel();
    if (m.vd) return m;
    e = m.n + 1;
    if (m.sstart < 0) begin
      if (m.dn == 32'd1 || m.ps == 32'd1) m.sstart = int'(e);
      else if (to != 0 && e == to) begin
        m.vd = 1'b1; m.vt = 1'b1; m.vp = 1'b0; m.vn = m.tn;
      end
    end else if (int'(e) == m.sstart + SETTLE) begin
      m.vd = 1'b1; m.vp = (m.dn == 32'd1) && (m.ps == 32'd1); m.vn = m.tn;
    end
    m.n = e;
    if (we && a != 5'd0) begin
      if (a == GP)  m.tn = d;
      if (a == S10) m.dn = d;
      if (a == S11) m.ps = d;
    end
    return m;
  endfunction

  function automatic out_t modelOut(model_t m);
    return {m.vd, m.vp, m.vd && !m.vp, m.vt, m.vn, m.n};
  endfunction

  function automatic out_t mkOut(bit d, bit p, bit f, bit t, int num, int cyc);
    return {d, p, f, t, 32'(num), 32'(cyc)};
  endfunction

  function automatic vec_t mkVec(int rep, bit we, logic [4:0] addr, int data,
                                 bit clr, out_t exp);
    vec_t v;
    v.rep = rep; v.we = we; v.addr = addr; v.data = 32'(data); v.clr = clr; v.exp = exp;
    return v;
  endfunction

  task automatic checkOutput(input string name, input out_t act, input out_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got done=%0b pass=%0b fail=%0b to=%0b num=%0d cyc=%0d, want done=%0b pass=%0b fail=%0b to=%0b num=%0d cyc=%0d",
               name, act.done, act.pass, act.fail, act.tmo, act.num, act.cyc,
               exp.done, exp.pass, exp.fail, exp.tmo, exp.num, exp.cyc);
    end
  endtask

  // Drive one cycle of inputs, advance the models over the edge, compare both DUTs
  task automatic applyStimulus(input bit we, input logic [4:0] addr,
                               input logic [31:0] data, input bit clr);
    wb_we = we; wb_waddr = addr; wb_wdata = data; clear = clr;
    @(posedge clk);
    ma = stepModel(ma, we, addr, data, clr, TO_A);
    mb = stepModel(mb, we, addr, data, clr, TO_B);
    #1;
    checkOutput("model_a", out_a, modelOut(ma));
    checkOutput("model_b", out_b, modelOut(mb));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 5'd0, 32'd0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; wb_we = 1'b0; wb_waddr = '0; wb_wdata = '0; clear = 1'b0;
    ma = zeroModel(); mb = zeroModel();

    vecs[0]  = mkVec(4,  0, 0,   0, 0, mkOut(0, 0, 0, 0, 0, 4));
    vecs[1]  = mkVec(1,  1, S11, 1, 0, mkOut(0, 0, 0, 0, 0, 5));
    vecs[2]  = mkVec(1,  0, 0,   0, 0, mkOut(0, 0, 0, 0, 0, 6));
    vecs[3]  = mkVec(1,  1, S10, 1, 0, mkOut(0, 0, 0, 0, 0, 7));
    vecs[4]  = mkVec(8,  0, 0,   0, 0, mkOut(0, 0, 0, 0, 0, 15));
    vecs[5]  = mkVec(1,  0, 0,   0, 0, mkOut(1, 1, 0, 0, 0, 16));
    vecs[6]  = mkVec(3,  0, 0,   0, 0, mkOut(1, 1, 0, 0, 0, 16));
    vecs[7]  = mkVec(1,  1, GP,  9, 0, mkOut(1, 1, 0, 0, 0, 16));
    vecs[8]  = mkVec(1,  0, 0,   0, 1, mkOut(0, 0, 0, 0, 0, 0));
    vecs[9]  = mkVec(1,  1, GP,  5, 0, mkOut(0, 0, 0, 0, 0, 1));
    vecs[10] = mkVec(1,  1, S11, 1, 0, mkOut(0, 0, 0, 0, 0, 2));
    vecs[11] = mkVec(10, 0, 0,   0, 0, mkOut(0, 0, 0, 0, 0, 12));
    vecs[12] = mkVec(1,  0, 0,   0, 0, mkOut(1, 0, 1, 0, 5, 13));
    vecs[13] = mkVec(1,  1, S11, 1, 1, mkOut(0, 0, 0, 0, 0, 0));
    vecs[14] = mkVec(12, 0, 0,   0, 0, mkOut(0, 0, 0, 0, 0, 12));
    vecs[15] = mkVec(1,  0, 0,   0, 1, mkOut(0, 0, 0, 0, 0, 0));
    vecs[16] = mkVec(1,  1, S10, 2, 0, mkOut(0, 0, 0, 0, 0, 1));
    vecs[17] = mkVec(1,  1, 0,   1, 0, mkOut(0, 0, 0, 0, 0, 2));
    vecs[18] = mkVec(12, 0, 0,   0, 0, mkOut(0, 0, 0, 0, 0, 14));
    vecs[19] = mkVec(1,  1, S10, 1, 0, mkOut(0, 0, 0, 0, 0, 15));
    vecs[20] = mkVec(10, 0, 0,   0, 0, mkOut(0, 0, 0, 0, 0, 25));
    vecs[21] = mkVec(1,  0, 0,   0, 0, mkOut(1, 0, 1, 0, 0, 26));
    vecs[22] = mkVec(1,  0, 0,   0, 1, mkOut(0, 0, 0, 0, 0, 0));
    vecs[23] = mkVec(49, 0, 0,   0, 0, mkOut(0, 0, 0, 0, 0, 49));
    vecs[24] = mkVec(1,  0, 0,   0, 0, mkOut(1, 0, 1, 1, 0, 50));
    vecs[25] = mkVec(5,  0, 0,   0, 0, mkOut(1, 0, 1, 1, 0, 50));
    vecs[26] = mkVec(1,  0, 0,   0, 1, mkOut(0, 0, 0, 0, 0, 0));

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    checkOutput("reset_state", out_a, mkOut(0, 0, 0, 0, 0, 0));

    for (int i = 0; i < 27; i++) begin
      for (int r = 0; r < vecs[i].rep; r++)
        applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].clr);
      checkOutput($sformatf("vec%0d", i), out_a, vecs[i].exp);
    end

    // Disabled watchdog: no verdict after a long idle stretch
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1);
    idle(1000);
    checkOutput("no_timeout", out_b, mkOut(0, 0, 0, 0, 0, 1000));
    checkOutput("timeout_a", out_a, mkOut(1, 0, 1, 1, 0, 50));

    // Asynchronous reset in the middle of the settle window
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1);
    applyStimulus(1'b1, S11, 32'd1, 1'b0);
    applyStimulus(1'b1, S10, 32'd1, 1'b0);
    idle(3);
    #2 rst_n = 1'b0;
    #1;
    ma = zeroModel(); mb = zeroModel();
    checkOutput("async_reset", out_a, mkOut(0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    applyStimulus(1'b1, S10, 32'd1, 1'b0);
    applyStimulus(1'b1, S11, 32'd1, 1'b0);
    idle(9);
    checkOutput("post_reset_wait", out_a, mkOut(0, 0, 0, 0, 0, 11));
    idle(1);
    checkOutput("post_reset_pass", out_a, mkOut(1, 1, 0, 0, 0, 12));

    // Randomized write-back traffic
    for (int ep = 0; ep < 30; ep++) begin
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b1);
      for (int c = 0; c < 60; c++) begin
        logic [4:0]  a;
        logic [31:0] d;
        case ($urandom_range(0, 4))
          0: a = 5'd0;
          1: a = GP;
          2: a = S10;
          3: a = S11;
          default: a = 5'($urandom);
        endcase
        case ($urandom_range(0, 3))
          0: d = 32'd0;
          1: d = 32'd1;
          2: d = 32'd2;
          default: d = $urandom;
        endcase
        applyStimulus($urandom_range(0, 2) == 0, a, d, $urandom_range(0, 49) == 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/riscv_test_monitor.md
# riscv_test_monitor

Synthesizable, parametrised pass/fail monitor for riscv-tests style programs running on `risc_v_cpu`. It snoops the register-file write-back port and keeps shadow copies of the test-number, done and pass registers. After a configurable settle window it renders a sticky verdict; a watchdog timeout also ends the test. It sits beside `regs` in the CPU top, so simulation benches and FPGA builds share one verdict source instead of hierarchical peeks.

## Interface
- `DATA_W`, 32, register data width
- `ADDR_W`, 5, register address width
- `TNUM_REG`, 3, index of test-number register (gp)
- `DONE_REG`, 26, index of done-flag register
- `PASS_REG`, 27, index of pass-flag register
- `SETTLE_CYC`, 10, cycles between trigger and verdict (≥1)
- `TIMEOUT_CYC`, 100000, watchdog limit in cycles; 0 disables
- `CNT_W`, 32, cycle-counter width

Ports:
- `clk`  in  1  clock. One clock domain.
- `rst_n`  in  1  reset. Asynchronous, active-low.
- `wb_we_i`  in  1  register-file write enable
- `wb_waddr_i`  in  ADDR_W  write address
- `wb_wdata_i`  in  DATA_W  write data
- `clear_i`  in  1  synchronous restart for the next test image
- `test_done_o`  out  1  verdict valid (sticky)
- `test_pass_o`  out  1  pass verdict
- `test_fail_o`  out  1  fail verdict (includes timeout)
- `test_timeout_o`  out  1  watchdog expired
- `test_num_o`  out  DATA_W  shadow of TNUM_REG, frozen at the verdict
- `cycle_cnt_o`  out  CNT_W  cycles since reset/clear, frozen at the verdict

## Operation

**Shadow registers**
- `tnum`, `done`, `pass`; all reset to 0.
- Updated at an edge where `wb_we_i`=1 and `wb_waddr_i` matches the index.
- Writes with `wb_waddr_i`=0 are ignored.
- Shadows update in RUN and SETTLE; they are frozen in DONE.

**FSM**
- States: RUN, SETTLE, DONE. Reset state is RUN.
- RUN → SETTLE when the registered `done`==1 or `pass`==1. Only the value 1 triggers; other values do not.
- RUN → DONE with timeout when `TIMEOUT_CYC`≠0 and `cycle_cnt`==`TIMEOUT_CYC`-1 with no trigger that cycle. The trigger has priority over the timeout.
- SETTLE: the settle counter starts at 0 and increments each cycle. When the counter reaches `SETTLE_CYC`-1, the next edge enters DONE.
- SETTLE → DONE sets the verdict from the shadows at that edge:
  - pass = (`done`==1 && `pass`==1)
  - fail = !pass
- The watchdog is not evaluated in SETTLE.
- DONE holds all outputs until `clear_i` or reset.

**Outputs and counter**
- `test_fail_o`=1 whenever `test_timeout_o`=1.
- `test_pass_o` and `test_fail_o` are never both 1.
- Both are 0 while `test_done_o`=0.
- `cycle_cnt` increments in RUN and SETTLE, saturates at all-ones, and freezes in DONE.

**clear_i**
- Next state RUN.
- Zeroes the shadows, both counters and all outputs.
- Has priority over the write, the trigger and the timeout in the same cycle; a coincident write is dropped.

**Reset**
- Reset mid-operation (any state) zeroes everything asynchronously.

## Timing
- All outputs are registered. Every output resets to 0.
- Trigger write at edge k:
  - shadow valid after edge k
  - SETTLE entered at edge k+1
  - `test_done_o` high after edge k+1+`SETTLE_CYC`
- With `TIMEOUT_CYC`=N and no trigger, DONE (timeout) is entered at edge N after reset/clear, with `cycle_cnt_o`=N.
- A write to `DONE_REG`/`PASS_REG` during SETTLE changes the verdict but does not restart the window.
- The verdict and `test_num_o` change only on entry to DONE or on clear/reset.

## Structure
- Package `test_mon_pkg`:
  - state enum (RUN/SETTLE/DONE)
  - ABI index constants: GP=3, S10=26, S11=27
  - default `SETTLE_CYC` and `TIMEOUT_CYC`
- Sub-module `mon_sat_cnt`: saturating up-counter with synchronous clear, enable and width parameter. It is instantiated twice: once for the cycle count and once for the settle count.
- The FSM and shadows live in the top module.

## Test plan
- `PASS_REG`←1 at edge 5, `DONE_REG`←1 at edge 7, `SETTLE_CYC`=10: done=1 after edge 16, pass=1, fail=0, timeout=0.
- `TNUM_REG`←5, then `PASS_REG`←1 only: after the settle window fail=1, pass=0, `test_num_o`=5.
- No writes, `TIMEOUT_CYC`=50: after edge 50 done=1, timeout=1, fail=1, `cycle_cnt_o`=50. Repeat with `TIMEOUT_CYC`=0: no verdict after 1000 cycles.
- `DONE_REG`←2: no trigger. Write with `wb_waddr_i`=0 and data 1: shadows unchanged. Then `DONE_REG`←1: trigger.
- In DONE, `clear_i`=1: all outputs 0 after the next edge and the FSM is in RUN. Then `clear_i` in the same cycle as `PASS_REG`←1: the write is dropped and there is no trigger.
- `rst_n` asserted mid-SETTLE, then released: all outputs 0, shadows 0, FSM in RUN, and a fresh pass sequence produces pass.
